// File: rtl/cla_arb_pkg.sv
// Shared widths for the arbitrated carry-lookahead adder block.
package cla_arb_pkg;

  localparam int ADD_W = 32;
  localparam int SUM_W = ADD_W + 1;
  localparam int GRP_W = 4;

endpackage

// File: rtl/CarryLookHeadAdder.sv
// 32-bit carry-lookahead adder: 4-bit lookahead groups chained by group generate/propagate.
module CarryLookHeadAdder
  import cla_arb_pkg::*;
(
  input  logic [ADD_W-1:0] A,
  input  logic [ADD_W-1:0] B,
  output logic [SUM_W-1:0] Sum
);

  localparam int NGRP = ADD_W / GRP_W;

  logic [ADD_W-1:0] g;
  logic [ADD_W-1:0] p;
  logic [ADD_W:0]   c;
  logic [NGRP-1:0]  gg;
  logic [NGRP-1:0]  pg;

  assign g    = A & B;
  assign p    = A ^ B;
  assign c[0] = 1'b0;

  for (genvar j = 0; j < NGRP; j++) begin : g_grp
    localparam int B0 = j * GRP_W;

    assign c[B0+1] = g[B0] | (p[B0] & c[B0]);
    assign c[B0+2] = g[B0+1] | (p[B0+1] & g[B0]) | (p[B0+1] & p[B0] & c[B0]);
    assign c[B0+3] = g[B0+2] | (p[B0+2] & g[B0+1]) | (p[B0+2] & p[B0+1] & g[B0])
                   | (p[B0+2] & p[B0+1] & p[B0] & c[B0]);

    // Group terms let the carry skip a whole nibble in one gate level.
    assign gg[j] = g[B0+3] | (p[B0+3] & g[B0+2]) | (p[B0+3] & p[B0+2] & g[B0+1])
                 | (p[B0+3] & p[B0+2] & p[B0+1] & g[B0]);
    assign pg[j] = p[B0+3] & p[B0+2] & p[B0+1] & p[B0];

    assign c[B0+4] = gg[j] | (pg[j] & c[B0]);
  end

  assign Sum = {c[ADD_W], p ^ c[ADD_W-1:0]};

endmodule

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: first set request at or above ptr, wrapping modulo N.
module rr_arbiter #(
  parameter  int N  = 4,
  localparam int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  input  logic          en,
  output logic [N-1:0]  gnt,
  output logic [IW-1:0] gnt_id
);

  localparam logic [IW:0] NV = (IW + 1)'(N);

  logic [IW:0] idx;
  logic        found;

  always_comb begin
    gnt    = '0;
    gnt_id = '0;
    found  = 1'b0;
    idx    = '0;
    for (int k = 0; k < N; k++) begin
      idx = {1'b0, ptr} + (IW + 1)'(k);
      if (idx >= NV) idx = idx - NV;
      if (en && !found && req[idx[IW-1:0]]) begin
        found              = 1'b1;
        gnt[idx[IW-1:0]]   = 1'b1;
        gnt_id             = idx[IW-1:0];
      end
    end
  end

endmodule

// File: rtl/cla_add_arbiter.sv
// Round-robin sharing of one carry-lookahead adder among NREQ requesters,
// with a one-entry tagged result register.
module cla_add_arbiter
  import cla_arb_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int IDW  = $clog2(NREQ)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NREQ-1:0]       req_valid,
  output logic [NREQ-1:0]       req_ready,
  input  logic [NREQ*ADD_W-1:0] req_a,
  input  logic [NREQ*ADD_W-1:0] req_b,
  input  logic [NREQ-1:0]       req_mask,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [SUM_W-1:0]      rsp_sum,
  output logic [IDW-1:0]        rsp_id,
  output logic [31:0]           op_count
);

  // Handshake: a transfer happens on a side when valid && ready at the rising
  // edge. Sources hold valid and data until ready; ready here is derived from
  // valid (never the reverse), and rsp_valid/rsp_sum/rsp_id stay put until rsp_ready.

  logic [NREQ-1:0]  eligible;
  logic [NREQ-1:0]  gnt;
  logic [IDW-1:0]   gnt_id;
  logic [IDW-1:0]   ptr;
  logic [IDW-1:0]   ptr_nxt;
  logic             slot_free;
  logic             xfer;
  logic [ADD_W-1:0] op_a;
  logic [ADD_W-1:0] op_b;
  logic [SUM_W-1:0] sum;

  assign eligible  = req_valid & req_mask;
  assign slot_free = !rsp_valid || rsp_ready;

  // Gating with rst_n keeps every ready low during reset cycles.
  rr_arbiter #(.N(NREQ)) u_arb (
    .req    (eligible),
    .ptr    (ptr),
    .en     (slot_free && rst_n),
    .gnt    (gnt),
    .gnt_id (gnt_id)
  );

  assign req_ready = gnt;
  assign xfer      = |gnt;

  assign op_a = req_a[int'(gnt_id)*ADD_W +: ADD_W];
  assign op_b = req_b[int'(gnt_id)*ADD_W +: ADD_W];

  CarryLookHeadAdder u_add (
    .A   (op_a),
    .B   (op_b),
    .Sum (sum)
  );

  assign ptr_nxt = (gnt_id == IDW'(NREQ - 1)) ? '0 : gnt_id + 1'b1;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rsp_valid <= 1'b0;
      rsp_sum   <= '0;
      rsp_id    <= '0;
      ptr       <= '0;
      op_count  <= '0;
    end else begin
      if (xfer) begin
        rsp_valid <= 1'b1;
        rsp_sum   <= sum;
        rsp_id    <= gnt_id;
        ptr       <= ptr_nxt;
        op_count  <= op_count + 32'd1;
      end else if (rsp_valid && rsp_ready) begin
        rsp_valid <= 1'b0;
      end
    end
  end

  a_ready_onehot : assert property (@(posedge clk) disable iff (!rst_n)
    $onehot0(req_ready));

  a_rsp_hold : assert property (@(posedge clk) disable iff (!rst_n)
    (rsp_valid && !rsp_ready) |=> (rsp_valid && $stable(rsp_sum) && $stable(rsp_id)));

endmodule

// File: tb/tb_cla_add_arbiter.sv
// Directed bench for cla_add_arbiter: grant order, sums, stall hold, masking and reset.
module tb_cla_add_arbiter;

  localparam int NREQ = 4;
  localparam int IDW  = 2;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [NREQ-1:0]   req_valid;
  logic [NREQ-1:0]   req_ready;
  logic [NREQ*32-1:0] req_a;
  logic [NREQ*32-1:0] req_b;
  logic [NREQ-1:0]   req_mask;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [32:0]       rsp_sum;
  logic [IDW-1:0]    rsp_id;
  logic [31:0]       op_count;

  int n_checks = 0;
  int n_pass   = 0;
  logic [IDW-1:0] exp_q[$];

  cla_add_arbiter #(.NREQ(NREQ), .IDW(IDW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_a     (req_a),
    .req_b     (req_b),
    .req_mask  (req_mask),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_sum   (rsp_sum),
    .rsp_id    (rsp_id),
    .op_count  (op_count)
  );

  // clock / reset
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp);
  endtask

  // driver tasks
  task automatic set_op(input int i, input logic [31:0] a, input logic [31:0] b);
    req_a[i*32 +: 32] = a;
    req_b[i*32 +: 32] = b;
  endtask

  task automatic set_rot_ops();
    set_op(0, 32'h0000_0010, 32'h0000_0001);
    set_op(1, 32'h0000_0020, 32'h0000_0002);
    set_op(2, 32'h0000_0030, 32'h0000_0003);
    set_op(3, 32'hF000_0000, 32'h2000_0000);
  endtask

  // Check the grant this cycle, then the tagged result after the edge.
  task automatic grant_step(input logic [NREQ-1:0] exp_rdy, input logic [IDW-1:0] id,
                            input logic [32:0] exp_sum);
    check("req_ready", 64'(req_ready), 64'(exp_rdy));
    exp_q.push_back(id);
    tick();
    check("rsp_valid", 64'(rsp_valid), 64'd1);
    check("rsp_id", 64'(rsp_id), 64'(exp_q.pop_front()));
    check("rsp_sum", 64'(rsp_sum), 64'(exp_sum));
  endtask

  initial begin
    rst_n     = 1'b0;
    req_valid = '1;
    req_mask  = '1;
    rsp_ready = 1'b1;
    req_a     = '0;
    req_b     = '0;
    #1;
    check("ready_in_reset", 64'(req_ready), 64'd0);
    tick();
    tick();
    check("rst_valid", 64'(rsp_valid), 64'd0);
    check("rst_sum", 64'(rsp_sum), 64'd0);
    check("rst_id", 64'(rsp_id), 64'd0);
    check("rst_count", 64'(op_count), 64'd0);
    check("rst_ready", 64'(req_ready), 64'd0);

    // single requester, carry out
    rst_n     = 1'b1;
    set_op(0, 32'hFFFF_FFFF, 32'h0000_0001);
    req_valid = 4'b0001;
    #1;
    grant_step(4'b0001, 2'd0, 33'h1_0000_0000);
    check("count_single", 64'(op_count), 64'd1);
    req_valid = 4'b0000;
    tick();
    check("drain_valid", 64'(rsp_valid), 64'd0);
    check("drain_sum_hold", 64'(rsp_sum), 64'h1_0000_0000);

    // full rotation from ptr 0, no bubbles
    do_reset();
    set_rot_ops();
    req_valid = 4'b1111;
    #1;
    grant_step(4'b0001, 2'd0, 33'h0_0000_0011);
    grant_step(4'b0010, 2'd1, 33'h0_0000_0022);
    grant_step(4'b0100, 2'd2, 33'h0_0000_0033);
    grant_step(4'b1000, 2'd3, 33'h1_1000_0000);
    grant_step(4'b0001, 2'd0, 33'h0_0000_0011);
    check("count_rot", 64'(op_count), 64'd5);

    // stall: result held, no grants, ptr frozen at 2
    req_valid = 4'b0000;
    tick();
    check("idle_valid", 64'(rsp_valid), 64'd0);
    set_op(1, 32'h1234_5670, 32'h0000_0008);
    req_valid = 4'b0010;
    rsp_ready = 1'b0;
    #1;
    grant_step(4'b0010, 2'd1, 33'h0_1234_5678);
    set_rot_ops();
    req_valid = 4'b1111;
    #1;
    for (int c = 0; c < 3; c++) begin
      check("stall_ready", 64'(req_ready), 64'd0);
      tick();
      check("stall_valid", 64'(rsp_valid), 64'd1);
      check("stall_sum", 64'(rsp_sum), 64'h0_1234_5678);
      check("stall_id", 64'(rsp_id), 64'd1);
    end
    check("count_stall", 64'(op_count), 64'd6);
    rsp_ready = 1'b1;
    #1;
    grant_step(4'b0100, 2'd2, 33'h0_0000_0033);
    check("count_resume", 64'(op_count), 64'd7);

    // reset while stalled discards the held result
    rsp_ready = 1'b0;
    #1;
    check("stalled_ready", 64'(req_ready), 64'd0);
    rst_n = 1'b0;
    #1;
    check("rst_stall_ready", 64'(req_ready), 64'd0);
    tick();
    check("rst_stall_valid", 64'(rsp_valid), 64'd0);
    check("rst_stall_count", 64'(op_count), 64'd0);
    rst_n     = 1'b1;
    req_valid = 4'b0000;
    tick();
    check("post_rst_valid", 64'(rsp_valid), 64'd0);

    // mask 1011: requester 2 skipped, first grant to lowest index
    rsp_ready = 1'b1;
    req_mask  = 4'b1011;
    req_valid = 4'b1111;
    #1;
    grant_step(4'b0001, 2'd0, 33'h0_0000_0011);
    grant_step(4'b0010, 2'd1, 33'h0_0000_0022);
    grant_step(4'b1000, 2'd3, 33'h1_1000_0000);
    grant_step(4'b0001, 2'd0, 33'h0_0000_0011);
    req_mask = 4'b0000;
    #1;
    check("all_masked", 64'(req_ready), 64'd0);

    // bring ptr to 2, then 1 and 3 compete
    req_mask  = 4'b1111;
    req_valid = 4'b0010;
    #1;
    grant_step(4'b0010, 2'd1, 33'h0_0000_0022);
    set_op(1, 32'h8000_0000, 32'h8000_0000);
    set_op(3, 32'h8000_0000, 32'h8000_0000);
    req_valid = 4'b1010;
    #1;
    grant_step(4'b1000, 2'd3, 33'h1_0000_0000);
    grant_step(4'b0010, 2'd1, 33'h1_0000_0000);
    check("count_final", 64'(op_count), 64'd7);
    req_valid = 4'b0000;
    tick();
    check("final_drain", 64'(rsp_valid), 64'd0);

    // report
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
